// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester bundle plus the RAM port of the shared memory arbiter.
// slave = arbiter view; master = core and memory side view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_ack;
  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ack;
  logic                  m_en;
  logic [DATA_W/8-1:0]   m_we;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W-1:0]     m_rdata;
  logic                  busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported RAM between fetch and data ports; data wins, or alternate under ARB_ROUND_ROBIN_EN.
// Ack arrives 2+MEM_LAT cycles after the grant edge; a losing requester waits in IDLE holding its req.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus_if
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              store_q, store_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              m_en_q, m_en_d;
  logic [BE_W-1:0]   m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q;
  logic              pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner_q;

  // Under contention the port that did not win last time goes first.
  always_comb pick_d = bus_if.d_req && (!bus_if.i_req || last_owner_q == OWN_I);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner_q <= OWN_I;
    end else if (state_q == IDLE && (bus_if.i_req || bus_if.d_req)) begin
      last_owner_q <= pick_d ? OWN_D : OWN_I;
    end
  end
`else
  always_comb pick_d = bus_if.d_req;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    store_d   = store_q;
    cnt_d     = cnt_q;
    m_en_d    = 1'b0;
    m_we_d    = '0;
    m_addr_d  = '0;
    m_wdata_d = '0;
    i_ack_d   = 1'b0;
    i_rdata_d = '0;
    d_ack_d   = 1'b0;
    d_rdata_d = '0;
    case (state_q)
      IDLE: begin
        // The ISSUE-cycle memory registers double as the captured request fields.
        if (bus_if.i_req || bus_if.d_req) begin
          state_d  = ISSUE;
          m_en_d   = 1'b1;
          owner_d  = pick_d ? OWN_D : OWN_I;
          store_d  = pick_d && bus_if.d_we;
          m_addr_d = pick_d ? bus_if.d_addr : bus_if.i_addr;
          if (pick_d && bus_if.d_we) begin
            m_we_d    = bus_if.d_be;
            m_wdata_d = bus_if.d_wdata;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 2'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = store_q ? '0 : bus_if.m_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus_if.m_rdata;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      store_q   <= 1'b0;
      cnt_q     <= 2'd0;
      m_en_q    <= 1'b0;
      m_we_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      store_q   <= store_d;
      cnt_q     <= cnt_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus_if.m_en    = m_en_q;
  assign bus_if.m_we    = m_we_q;
  assign bus_if.m_addr  = m_addr_q;
  assign bus_if.m_wdata = m_wdata_q;
  assign bus_if.i_ack   = i_ack_q;
  assign bus_if.i_rdata = i_rdata_q;
  assign bus_if.d_ack   = d_ack_q;
  assign bus_if.d_rdata = d_rdata_q;
  assign bus_if.busy    = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table plus reset-abort and contention sequences.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 1;

  localparam logic [31:0] INST = 32'h2008_0005;
  localparam logic [31:0] DB   = 32'hDEAD_BEEF;
  localparam logic [31:0] DBA  = 32'hDEAD_BEAA;
  localparam logic [31:0] A40  = 32'h0000_0040;
  localparam logic [31:0] A100 = 32'h0000_0100;

  typedef struct packed {
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } in_t;

  typedef struct packed {
    logic        m_en;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  // Synchronous RAM model: read returns old contents MEM_LAT cycles after m_en.
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [MEM_LAT];

  always @(posedge clk) begin
    if (bus.m_en) begin
      rd_pipe[0] <= mem[bus.m_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus.m_we[b]) mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
    end
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.m_rdata = rd_pipe[MEM_LAT-1];

  function automatic in_t fin(logic rn, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [3:0] be, logic [31:0] da, logic [31:0] wd);
    return '{rst_n: rn, i_req: ir, i_addr: ia, d_req: dr, d_we: dw, d_be: be, d_addr: da, d_wdata: wd};
  endfunction

  function automatic out_t fout(logic en, logic [3:0] we, logic [31:0] a, logic [31:0] wd, logic ia,
                                logic [31:0] ird, logic da, logic [31:0] drd, logic bz);
    return '{m_en: en, m_we: we, m_addr: a, m_wdata: wd, i_ack: ia, i_rdata: ird,
             d_ack: da, d_rdata: drd, busy: bz};
  endfunction

  function automatic out_t sample();
    return '{m_en: bus.m_en, m_we: bus.m_we, m_addr: bus.m_addr, m_wdata: bus.m_wdata,
             i_ack: bus.i_ack, i_rdata: bus.i_rdata, d_ack: bus.d_ack, d_rdata: bus.d_rdata,
             busy: bus.busy};
  endfunction

  task automatic apply(input in_t v);
    rst         = v.rst_n;
    bus.i_req   = v.i_req;
    bus.i_addr  = v.i_addr;
    bus.d_req   = v.d_req;
    bus.d_we    = v.d_we;
    bus.d_be    = v.d_be;
    bus.d_addr  = v.d_addr;
    bus.d_wdata = v.d_wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input out_t got, input out_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  vec_t vecs[$];
  out_t ZERO;
  out_t s;
  int   n_ack, n_tx, cyc, gnt_cyc;
  logic exp_own[4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[A40[9:2]] = INST;
    ZERO = fout(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset, single fetch, full store, load, byte store, load.
    vecs.push_back('{fin(0, 0, 0, 0, 0, 0, 0, 0), ZERO});
    vecs.push_back('{fin(1, 1, A40, 0, 0, 0, 0, 0), fout(1, 0, A40, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 1, A40, 0, 0, 0, 0, 0), fout(0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 1, A40, 0, 0, 0, 0, 0), fout(0, 0, 0, 0, 1, INST, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 0, 0, 0, 0, 0), ZERO});
    vecs.push_back('{fin(1, 0, 0, 1, 1, 4'hF, A100, DB), fout(1, 4'hF, A100, DB, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 1, 4'hF, A100, DB), fout(0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 1, 4'hF, A100, DB), fout(0, 0, 0, 0, 0, 0, 1, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 0, 0, A100, 0), ZERO});
    vecs.push_back('{fin(1, 0, 0, 1, 0, 0, A100, 0), fout(1, 0, A100, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 0, 0, A100, 0), fout(0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 0, 0, A100, 0), fout(0, 0, 0, 0, 0, 0, 1, DB, 1)});
    vecs.push_back('{fin(1, 0, 0, 0, 0, 0, 0, 0), ZERO});
    vecs.push_back('{fin(1, 0, 0, 1, 1, 4'h1, A100, 32'hAA), fout(1, 4'h1, A100, 32'hAA, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 1, 4'h1, A100, 32'hAA), fout(0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 1, 4'h1, A100, 32'hAA), fout(0, 0, 0, 0, 0, 0, 1, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 0, 0, A100, 0), ZERO});
    vecs.push_back('{fin(1, 0, 0, 1, 0, 0, A100, 0), fout(1, 0, A100, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 0, 0, A100, 0), fout(0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{fin(1, 0, 0, 1, 0, 0, A100, 0), fout(0, 0, 0, 0, 0, 0, 1, DBA, 1)});
    vecs.push_back('{fin(1, 0, 0, 0, 0, 0, 0, 0), ZERO});

    foreach (vecs[k]) begin
      apply(vecs[k].in);
      step();
      chk_out($sformatf("vec%0d", k), sample(), vecs[k].exp);
    end

    // Reset while the fetch is in WAIT: no ack, then a fresh fetch completes.
    apply(fin(1, 1, A40, 0, 0, 0, 0, 0));
    step(); chk_out("rst_issue", sample(), fout(1, 0, A40, 0, 0, 0, 0, 0, 1));
    step(); chk_out("rst_wait", sample(), fout(0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst = 1'b0;
    step(); chk_out("rst_abort", sample(), ZERO);
    step(); chk_out("rst_hold", sample(), ZERO);
    rst = 1'b1;
    step(); chk_out("refetch_issue", sample(), fout(1, 0, A40, 0, 0, 0, 0, 0, 1));
    step();
    step(); chk_out("refetch_ack", sample(), fout(0, 0, 0, 0, 1, INST, 0, 0, 1));
    bus.i_req = 1'b0;
    step(); chk_out("refetch_idle", sample(), ZERO);

    // Contention: both requests raised together.
`ifdef ARB_ROUND_ROBIN_EN
    n_tx = 4;
    exp_own[0] = 1'b1; exp_own[1] = 1'b0; exp_own[2] = 1'b1; exp_own[3] = 1'b0;
`else
    n_tx = 2;
    exp_own[0] = 1'b1; exp_own[1] = 1'b0; exp_own[2] = 1'b0; exp_own[3] = 1'b0;
`endif
    apply(fin(1, 1, A40, 1, 0, 0, A100, 0));
    n_ack = 0; cyc = 0; gnt_cyc = 0;
    while (n_ack < n_tx && cyc < 60) begin
      step();
      cyc++;
      s = sample();
      chk_val("ack_exclusive", {31'b0, s.i_ack & s.d_ack}, 32'd0);
      if (s.m_en) gnt_cyc = cyc;
      if (s.i_ack || s.d_ack) begin
        chk_val($sformatf("owner%0d", n_ack), {31'b0, s.d_ack}, {31'b0, exp_own[n_ack]});
        chk_val($sformatf("ack_lat%0d", n_ack), cyc - gnt_cyc, 1 + MEM_LAT);
        chk_val($sformatf("ack_data%0d", n_ack), s.d_ack ? s.d_rdata : s.i_rdata,
                s.d_ack ? DBA : INST);
        n_ack++;
        if (n_ack == n_tx) begin
          bus.i_req = 1'b0;
          bus.d_req = 1'b0;
        end else if (s.d_ack && n_tx == 2) begin
          bus.d_req = 1'b0;
        end
      end
    end
    chk_val("ack_count", n_ack, n_tx);
    step(); step();
    chk_out("final_idle", sample(), ZERO);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous RAM between the instruction-fetch port and the data (load/store) port of the pipelined MIPS core.
- Sequences each access as a fixed-latency transaction and returns data with a one-cycle ack pulse.
- Default policy: data port wins.
- Sits between the mips core and the unified memory; replaces separate inst/data memories.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width; the byte-enable width is DATA_W/8.
- MEM_LAT, 1, memory read latency: cycles from m_en to valid m_rdata. Legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- i_req  input  1  instruction fetch request; held until i_ack.
- i_addr  input  ADDR_W  fetch address; stable while i_req=1.
- i_rdata  output  DATA_W  fetched word; valid only while i_ack=1.
- i_ack  output  1  one-cycle completion pulse for fetch.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1=store, 0=load.
- d_be  input  DATA_W/8  store byte enables.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_rdata  output  DATA_W  load data; valid only while d_ack=1.
- d_ack  output  1  one-cycle completion pulse for data.
- m_en  output  1  memory access strobe, one cycle per transaction.
- m_we  output  DATA_W/8  memory byte write enables.
- m_addr  output  ADDR_W  memory address.
- m_wdata  output  DATA_W  memory write data.
- m_rdata  input  DATA_W  memory read data.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge): state=IDLE; all outputs are 0.
  - An in-flight transaction is abandoned with no ack.
  - A write already strobed is not undone.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples the requests and moves to ISSUE with a grant (owner = I or D).
  - If neither request is high, stays in IDLE.
  - Fixed priority: d_req over i_req.
  - Owner address, data, we and be are captured at the grant edge.
- ISSUE (exactly 1 cycle):
  - m_en=1 and m_addr = captured address.
  - If the owner is D with d_we=1: m_we=d_be and m_wdata=d_wdata.
  - Otherwise m_we=0 and m_wdata=0.
  - Next state is WAIT, with the latency counter loaded to MEM_LAT-1.
- WAIT:
  - m_en=0 and m_we=0.
  - Counter decrements each cycle.
  - At counter==0, m_rdata is captured into the owner's rdata register, ack is set, and the next state is RESP.
  - With MEM_LAT=1, WAIT lasts 1 cycle.
- RESP (1 cycle):
  - Owner ack=1 and owner rdata is valid. Stores return rdata=0.
  - Next state is IDLE. ack and rdata clear to 0 in IDLE.
- Latency: request sampled at edge T → m_en high in cycle T+1 → ack high in cycle T+2+MEM_LAT. Default: ack 3 cycles after grant.
- Throughput: one transaction per 3+MEM_LAT cycles; IDLE always lasts at least one cycle.
- Handshake:
  - A requester holds req, addr, wdata, we and be stable until it sees ack.
  - A request still high in the cycle after ack is a new request.
  - Dropping req before ack is illegal; the transaction completes anyway and its ack is ignored.
- Simultaneous requests: one is granted and the other waits in IDLE. Its fields are re-sampled at its own grant.
- A grant never switches mid-transaction.
- Ack exclusivity: i_ack and d_ack are never high in the same cycle.
- Addresses pass through unmodified. Word alignment is the requester's responsibility.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_owner flop (reset value I) is updated on every grant.
  - When both requests are high in IDLE, the port that was not last_owner wins.
  - A single request is granted immediately, as without the macro.
- Undefined: fixed data priority, and no last_owner flop exists.
  - A continuous d_req can starve fetch; the core never does this.

Test Plan:
- Reset mid-WAIT: i_req=1, then rst=0 at the cycle after m_en → no i_ack, all outputs 0, busy=0. After releasing rst with i_req=1, a fresh fetch completes.
- Single fetch, MEM_LAT=1: i_req=1, i_addr=0x40, memory holds 0x20080005 at 0x40 → m_en=1 with m_addr=0x40 one cycle after sampling, m_we=0. i_ack=1 with i_rdata=0x20080005 three cycles after sampling; busy low one cycle later.
- Store then load: d_req, d_we=1, d_be=0xF, d_addr=0x100, d_wdata=0xDEADBEEF → m_we=0xF in the ISSUE cycle only. d_ack fires with d_rdata=0. A following load from 0x100 returns 0xDEADBEEF.
- Byte store: d_be=0x1, d_wdata=0x000000AA to 0x100 (previously 0xDEADBEEF) → m_we=0x1; a following load returns 0xDEADBEAA.
- Contention, macro off: i_req and d_req high together and held → D granted first. I is granted on the next IDLE; no cycle has both acks high.
- Contention, ARB_ROUND_ROBIN_EN, MEM_LAT=3: both requests held high for 4 transactions → owner order D, I, D, I. Each ack arrives 5 cycles after its grant.
